// File: rtl/div_row_sequencer_pkg.sv
// Shared definitions for the output-normalisation row sequencer.
package div_row_sequencer_pkg;

  localparam int unsigned DEF_VEC_LEN         = 16;
  localparam int unsigned DEF_NUM_W           = 10;
  localparam int unsigned DEF_QUOT_W          = 8;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/div_row_sequencer.sv
// Normalises one attention output row: feeds each numerator with the shared
// row-sum denominator into the scalar divider, keeping up to MAX_OUTSTANDING
// divides in flight, and gathers the in-order quotients into one packed row.
//
// state | meaning
// IDLE  | waiting for a row; row_rdy_out high
// RUN   | issuing elements to the divider and collecting quotients
// DONE  | full quotient row presented on vec_out until downstream takes it
module div_row_sequencer
  import div_row_sequencer_pkg::*;
#(
  parameter int unsigned VEC_LEN         = DEF_VEC_LEN,
  parameter int unsigned NUM_W           = DEF_NUM_W,
  parameter int unsigned QUOT_W          = DEF_QUOT_W,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      row_vld_in,
  output logic                      row_rdy_out,
  input  logic [VEC_LEN*NUM_W-1:0]  row_num_in,
  input  logic [NUM_W-1:0]          row_den_in,
  output logic                      div_vld_out,
  input  logic                      div_rdy_in,
  output logic [NUM_W-1:0]          div_num_out,
  output logic [NUM_W-1:0]          div_den_out,
  input  logic                      quot_vld_in,
  output logic                      quot_rdy_out,
  input  logic [QUOT_W-1:0]         quot_in,
  output logic                      vec_vld_out,
  input  logic                      vec_rdy_in,
  output logic [VEC_LEN*QUOT_W-1:0] vec_out,
  output logic                      busy_out
);

  localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

  seq_state_e               state_q, state_d;
  logic [CNT_W-1:0]         iss_q, iss_d;
  logic [CNT_W-1:0]         ret_q, ret_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic [VEC_LEN*NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0]         den_q, den_d;
  logic [VEC_LEN*QUOT_W-1:0] vec_q, vec_d;

  logic             iss_fire;
  logic             ret_fire;
  logic [NUM_W-1:0] num_sel;

  // State, counters and row/quotient registers; reset discards any row in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      iss_q   <= '0;
      ret_q   <= '0;
      out_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      out_q   <= out_d;
      num_q   <= num_d;
      den_q   <= den_d;
      vec_q   <= vec_d;
    end
  end

  // Select the next element to issue; a mux over legal indices avoids an
  // out-of-range part-select once iss has counted past the last element.
  always_comb begin
    num_sel = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (iss_q == CNT_W'(i)) begin
        num_sel = num_q[i*NUM_W +: NUM_W];
      end
    end
  end

  // Next state: accept a row, track issue/return/credit counts, hand off the row.
  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    out_d   = out_q;
    num_d   = num_q;
    den_d   = den_q;
    vec_d   = vec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (row_vld_in) begin
          state_d = ST_RUN;
          num_d   = row_num_in;
          den_d   = row_den_in;
          iss_d   = '0;
          ret_d   = '0;
          out_d   = '0;
        end
      end
      ST_RUN: begin
        if (iss_fire) begin
          iss_d = iss_q + CNT_W'(1);
        end
        if (ret_fire) begin
          ret_d = ret_q + CNT_W'(1);
          // The divider returns in order, so the slot is simply the return count.
          for (int i = 0; i < VEC_LEN; i++) begin
            if (ret_q == CNT_W'(i)) begin
              vec_d[i*QUOT_W +: QUOT_W] = quot_in;
            end
          end
        end
        // A simultaneous issue and return leaves the credit count unchanged.
        case ({iss_fire, ret_fire})
          2'b10:   out_d = out_q + OUT_W'(1);
          2'b01:   out_d = out_q - OUT_W'(1);
          default: out_d = out_q;
        endcase
        if (ret_d == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (vec_rdy_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and handshake qualifiers, all derived from registered state.
  always_comb begin
    row_rdy_out  = (state_q == ST_IDLE);
    busy_out     = (state_q != ST_IDLE);
    div_vld_out  = (state_q == ST_RUN) && (iss_q < LAST_CNT) && (out_q < MAX_OUT);
    div_num_out  = num_sel;
    div_den_out  = den_q;
    quot_rdy_out = (state_q == ST_RUN) && (ret_q < LAST_CNT);
    vec_vld_out  = (state_q == ST_DONE);
    vec_out      = vec_q;
    iss_fire     = div_vld_out && div_rdy_in;
    ret_fire     = quot_vld_in && quot_rdy_out;
  end

endmodule

// File: tb/tb_div_row_sequencer.sv
// Bench for div_row_sequencer with a behavioural in-order divider stub.
module tb_div_row_sequencer;

  localparam int VL = 8;
  localparam int NW = 10;
  localparam int QW = 8;
  localparam int MO = 4;

  logic             clk;
  logic             rst;
  logic             row_vld_in;
  logic             row_rdy_out;
  logic [VL*NW-1:0] row_num_in;
  logic [NW-1:0]    row_den_in;
  logic             div_vld_out;
  logic             div_rdy_in;
  logic [NW-1:0]    div_num_out;
  logic [NW-1:0]    div_den_out;
  logic             quot_vld_in;
  logic             quot_rdy_out;
  logic [QW-1:0]    quot_in;
  logic             vec_vld_out;
  logic             vec_rdy_in;
  logic [VL*QW-1:0] vec_out;
  logic             busy_out;

  div_row_sequencer #(
    .VEC_LEN(VL), .NUM_W(NW), .QUOT_W(QW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .row_vld_in(row_vld_in), .row_rdy_out(row_rdy_out),
    .row_num_in(row_num_in), .row_den_in(row_den_in),
    .div_vld_out(div_vld_out), .div_rdy_in(div_rdy_in),
    .div_num_out(div_num_out), .div_den_out(div_den_out),
    .quot_vld_in(quot_vld_in), .quot_rdy_out(quot_rdy_out), .quot_in(quot_in),
    .vec_vld_out(vec_vld_out), .vec_rdy_in(vec_rdy_in), .vec_out(vec_out),
    .busy_out(busy_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // stub controls (written by main) and stub state (written by stub)
  int rdy_mode;
  int ret_mode;
  int ret_allow;
  int vec_mode;
  int base_mode;
  logic [QW-1:0] pend[$];
  int iss_cnt = 0;
  int ret_used = 0;

  // previous-cycle stall observations
  logic             p_div_stall, p_vec_stall;
  logic [NW-1:0]    p_num, p_den;
  logic [VL*QW-1:0] p_vec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Real-valued num/den scaled to Q0.7, rounded half away from zero, saturated.
  function automatic logic [QW-1:0] ref_div(input logic signed [NW-1:0] n, input logic signed [NW-1:0] d);
    int an, ad, q;
    if (d == 0) return (n < 0) ? 8'h80 : 8'h7f;
    an = (n < 0) ? -int'(n) : int'(n);
    ad = (d < 0) ? -int'(d) : int'(d);
    q = (an * 256 + ad) / (2 * ad);
    if ((n < 0) != (d < 0)) q = -q;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return QW'(q);
  endfunction

  function automatic logic [VL*QW-1:0] ref_row(input logic [VL*NW-1:0] nums, input logic [NW-1:0] den);
    logic [VL*QW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*QW +: QW] = ref_div(nums[i*NW +: NW], den);
    return r;
  endfunction

  // Four values repeated across the row; numerators use 1.0 = 64.
  function automatic logic [VL*NW-1:0] pk_num(input int a, input int b, input int c, input int d);
    logic [VL*NW-1:0] r;
    int v;
    for (int i = 0; i < VL; i++) begin
      v = (i % 4 == 0) ? a : (i % 4 == 1) ? b : (i % 4 == 2) ? c : d;
      r[i*NW +: NW] = NW'(v);
    end
    return r;
  endfunction

  function automatic logic [VL*QW-1:0] pk_q(input int a, input int b, input int c, input int d);
    logic [VL*QW-1:0] r;
    int v;
    for (int i = 0; i < VL; i++) begin
      v = (i % 4 == 0) ? a : (i % 4 == 1) ? b : (i % 4 == 2) ? c : d;
      r[i*QW +: QW] = QW'(v);
    end
    return r;
  endfunction

  // In-order divider stub, one cycle latency, optional random stalls.
  initial begin : stub
    logic ok, f_iss, f_ret;
    logic [NW-1:0] n_s, d_s;
    div_rdy_in = 1'b0;
    quot_vld_in = 1'b0;
    quot_in = '0;
    forever begin
      @(negedge clk);
      if (!rst) pend.delete();
      div_rdy_in = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      ok = (pend.size() > 0) &&
           ((ret_mode == 0) || (ret_mode == 1 && $urandom_range(0, 2) != 0) ||
            (ret_mode == 2 && ret_used < ret_allow));
      quot_vld_in = ok;
      quot_in = ok ? pend[0] : QW'($urandom);
      #1;
      f_iss = div_vld_out && div_rdy_in;
      f_ret = quot_vld_in && quot_rdy_out;
      n_s = div_num_out;
      d_s = div_den_out;
      @(posedge clk);
      if (rst) begin
        if (f_ret) begin
          void'(pend.pop_front());
          ret_used++;
        end
        if (f_iss) begin
          pend.push_back(ref_div(n_s, d_s));
          iss_cnt++;
        end
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_row_rdy", row_rdy_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_div_vld", div_vld_out, 0);
    chk("rst_div_num", div_num_out, 0);
    chk("rst_div_den", div_den_out, 0);
    chk("rst_quot_rdy", quot_rdy_out, 0);
    chk("rst_vec_vld", vec_vld_out, 0);
    chk("rst_vec_out", vec_out, 0);
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later.
  task automatic step();
    @(negedge clk);
    vec_rdy_in = (vec_mode == 0) ? 1'b1 : (vec_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    #1;
    if (p_div_stall) begin
      chk("div_stall_vld", div_vld_out, 1);
      chk("div_stall_num", div_num_out, p_num);
      chk("div_stall_den", div_den_out, p_den);
    end
    if (p_vec_stall) begin
      chk("vec_stall_vld", vec_vld_out, 1);
      chk("vec_stall_data", vec_out, p_vec);
    end
    chk("credit_bound", pend.size() <= MO, 1);
    p_div_stall = rst && div_vld_out && !div_rdy_in;
    p_num = div_num_out;
    p_den = div_den_out;
    p_vec_stall = rst && vec_vld_out && !vec_rdy_in;
    p_vec = vec_out;
  endtask

  task automatic offer_row(input logic [VL*NW-1:0] nums, input logic [NW-1:0] den, input bit lat_chk);
    logic acc;
    acc = 1'b0;
    row_num_in = nums;
    row_den_in = den;
    row_vld_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      acc = row_rdy_out;
      step();
      if (acc) break;
    end
    row_vld_in = 1'b0;
    chk("row_accept", acc, 1);
    chk("busy_after_accept", busy_out, 1);
    chk("rdy_low_after_accept", row_rdy_out, 0);
    if (lat_chk) chk("first_issue_lat", div_vld_out, 1);
  endtask

  task automatic finish_row(input logic [VL*QW-1:0] exp, input int hold, input bit lat_chk);
    logic seen, hs;
    int dn;
    seen = 1'b0;
    hs = 1'b0;
    dn = 0;
    vec_mode = (hold > 0) ? 2 : base_mode;
    for (int k = 1; k <= 2000 && !hs; k++) begin
      step();
      chk("rdy_low_in_row", row_rdy_out, 0);
      if (vec_vld_out) begin
        if (!seen) begin
          seen = 1'b1;
          if (lat_chk) chk("done_latency", k, VL + 1);
        end
        if (vec_rdy_in) begin
          chk("vec_out", vec_out, exp);
          hs = 1'b1;
        end else if (hold > 0) begin
          dn++;
          chk("bp_no_issue", div_vld_out, 0);
          if (dn >= hold) vec_mode = base_mode;
        end
      end
    end
    chk("row_complete", hs, 1);
    if (hs) begin
      step();
      chk("rdy_after_hs", row_rdy_out, 1);
      chk("idle_after_hs", busy_out, 0);
    end
    vec_mode = base_mode;
  endtask

  function automatic logic [VL*NW-1:0] rnd_nums();
    logic [VL*NW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*NW +: NW] = NW'($urandom);
    return r;
  endfunction

  initial begin : main
    logic [VL*NW-1:0] nums;
    logic [NW-1:0]    den;
    int base;
    rst = 1'b0;
    row_vld_in = 1'b0;
    row_num_in = '0;
    row_den_in = '0;
    vec_rdy_in = 1'b0;
    rdy_mode = 0;
    ret_mode = 0;
    ret_allow = 0;
    vec_mode = 0;
    base_mode = 0;
    p_div_stall = 1'b0;
    p_vec_stall = 1'b0;
    p_num = '0;
    p_den = '0;
    p_vec = '0;

    #3;
    chk_reset_vals();
    @(negedge clk);
    #1;
    rst = 1'b1;

    // basic row with latency checks
    offer_row(pk_num(0, 32, -32, 16), NW'(64), 1'b1);
    finish_row(pk_q(0, 64, -64, 32), 0, 1'b1);

    // downstream backpressure for 10 cycles
    nums = pk_num(16, -16, 48, -64);
    offer_row(nums, NW'(64), 1'b0);
    finish_row(pk_q(32, -32, 96, -128), 10, 1'b0);

    // credit limit with no returns, then a single return
    rdy_mode = 0;
    ret_mode = 2;
    ret_allow = ret_used;
    nums = rnd_nums();
    den = NW'(200);
    offer_row(nums, den, 1'b0);
    base = iss_cnt;
    for (int s = 1; s <= 9; s++) begin
      step();
      if (s == 3) chk("credit_s3", iss_cnt - base, 3);
      if (s == 4) begin
        chk("credit_s4", iss_cnt - base, 4);
        chk("credit_s4_vld", div_vld_out, 0);
      end
      if (s == 6) begin
        chk("credit_s6", iss_cnt - base, 4);
        chk("credit_s6_vld", div_vld_out, 0);
        ret_allow = ret_used + 1;
      end
      if (s == 8) begin
        chk("credit_s8", iss_cnt - base, 4);
        chk("credit_s8_vld", div_vld_out, 1);
      end
      if (s == 9) begin
        chk("credit_s9", iss_cnt - base, 5);
        chk("credit_s9_vld", div_vld_out, 0);
      end
    end
    ret_mode = 0;
    finish_row(ref_row(nums, den), 0, 1'b0);

    // zero and large denominators
    offer_row(pk_num(16, -16, 0, 64), NW'(0), 1'b0);
    finish_row(pk_q(127, -128, 127, 127), 0, 1'b0);
    offer_row(pk_num(64, 64, 64, 64), NW'(256), 1'b0);
    finish_row(pk_q(32, 32, 32, 32), 0, 1'b0);

    // reset mid-row after two issues
    ret_mode = 2;
    ret_allow = ret_used;
    offer_row(rnd_nums(), NW'(100), 1'b0);
    base = iss_cnt;
    for (int s = 0; s < 20 && (iss_cnt - base) < 2; s++) step();
    chk("rst_two_issues", iss_cnt - base, 2);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    p_div_stall = 1'b0;
    p_vec_stall = 1'b0;
    step();
    rst = 1'b1;
    ret_mode = 0;
    offer_row(pk_num(32, 32, 32, 32), NW'(64), 1'b0);
    finish_row(pk_q(64, 64, 64, 64), 0, 1'b0);

    // random rows under random stalls on every handshake
    rdy_mode = 1;
    ret_mode = 1;
    base_mode = 1;
    for (int r = 0; r < 1000; r++) begin
      nums = rnd_nums();
      den = ($urandom_range(0, 7) == 0) ? NW'(0) : NW'($urandom);
      offer_row(nums, den, 1'b0);
      finish_row(ref_row(nums, den), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
